// File: rtl/svf_multi_voice.sv
// Time-multiplexed Chamberlin state-variable filter for NUM_CH channels.
// One shared datapath walks HP -> BP -> LP; per-channel bp/lp state lives in flops.
module svf_multi_voice #(
  parameter  int NUM_CH  = 4,
  parameter  int DATA_W  = 8,
  parameter  int FRAC_W  = 1,
  parameter  int F_W     = 11,
  parameter  int F_SHIFT = 11,
  parameter  int Q_W     = 2,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int IW      = DATA_W + FRAC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CH_W-1:0]   in_chan,
  input  logic [DATA_W-1:0] in_data,
  input  logic [F_W-1:0]    in_alpha1,
  input  logic [Q_W-1:0]    in_alpha2,
  input  logic [1:0]        in_mode,
  input  logic              clr_valid,
  input  logic [CH_W-1:0]   clr_chan,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH_W-1:0]   out_chan,
  output logic [DATA_W-1:0] out_data
);

  // Wide enough that no product or sum can wrap before saturation.
  localparam int WW = IW + F_W + Q_W + 4;
  localparam logic signed [WW-1:0] SAT_MAX = WW'(2 ** (IW - 1) - 1);
  localparam logic signed [WW-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [2:0] {S_IDLE, S_HP, S_BP, S_LP, S_OUT} state_t;

  state_t state_q, state_d;

  logic signed [IW-1:0] bp_mem [NUM_CH];
  logic signed [IW-1:0] lp_mem [NUM_CH];

  logic [CH_W-1:0]      chan_q, out_chan_q;
  logic signed [IW-1:0] x_q, bp_q, lp_q, hp_q, bpn_q;
  logic signed [WW-1:0] fh_q, fb_q;
  logic [F_W-1:0]       a1_q;
  logic [Q_W-1:0]       a2_q;
  logic [1:0]           mode_q;
  logic                 out_valid_q;
  logic [DATA_W-1:0]    out_data_q;

  logic signed [WW-1:0] a1_w, a2_w, damp_w, fh_w, fb_w;
  logic signed [IW-1:0] hp_s, bpn_s, lpn_s, notch_s, sel_s;
  logic                 chan_ok, accept;

  function automatic logic signed [IW-1:0] sat(input logic signed [WW-1:0] v);
    if (v > SAT_MAX)      return SAT_MAX[IW-1:0];
    else if (v < SAT_MIN) return SAT_MIN[IW-1:0];
    else                  return v[IW-1:0];
  endfunction

  assign chan_ok   = {1'b0, in_chan} < (CH_W + 1)'(NUM_CH);
  assign in_ready  = (state_q == S_IDLE) && !clr_valid;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_chan  = out_chan_q;
  assign out_data  = out_data_q;

  always_comb begin
    a1_w    = WW'(a1_q);
    a2_w    = WW'(a2_q);
    damp_w  = (WW'(bp_q) * a2_w) >>> Q_W;
    hp_s    = sat(WW'(x_q) - WW'(lp_q) - damp_w);
    fh_w    = (WW'(hp_s) * a1_w) >>> F_SHIFT;
    bpn_s   = sat(WW'(bp_q) + fh_q);
    fb_w    = (WW'(bpn_s) * a1_w) >>> F_SHIFT;
    lpn_s   = sat(WW'(lp_q) + fb_q);
    notch_s = sat(WW'(hp_q) + WW'(lpn_s));
    case (mode_q)
      2'd0:    sel_s = lpn_s;
      2'd1:    sel_s = bpn_q;
      2'd2:    sel_s = hp_q;
      default: sel_s = notch_s;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Dropped channels are accepted but never leave IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && chan_ok) state_d = S_HP;
      S_HP:    state_d = S_BP;
      S_BP:    state_d = S_LP;
      S_LP:    state_d = S_OUT;
      S_OUT:   if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chan_q      <= '0;
      x_q         <= '0;
      bp_q        <= '0;
      lp_q        <= '0;
      a1_q        <= '0;
      a2_q        <= '0;
      mode_q      <= '0;
      hp_q        <= '0;
      fh_q        <= '0;
      bpn_q       <= '0;
      fb_q        <= '0;
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      out_data_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (accept && chan_ok) begin
          chan_q <= in_chan;
          x_q    <= {in_data, {FRAC_W{1'b0}}};
          bp_q   <= bp_mem[in_chan];
          lp_q   <= lp_mem[in_chan];
          a1_q   <= in_alpha1;
          a2_q   <= in_alpha2;
          mode_q <= in_mode;
        end
        S_HP: begin
          hp_q <= hp_s;
          fh_q <= fh_w;
        end
        S_BP: begin
          bpn_q <= bpn_s;
          fb_q  <= fb_w;
        end
        S_LP: begin
          out_data_q  <= DATA_W'(sel_s >>> FRAC_W);
          out_chan_q  <= chan_q;
          out_valid_q <= 1'b1;
        end
        S_OUT: if (out_ready) out_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  // Clears only happen in IDLE, so an in-flight writeback always lands first.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_state
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        bp_mem[gi] <= '0;
        lp_mem[gi] <= '0;
      end else if (state_q == S_IDLE && clr_valid && clr_chan == CH_W'(gi)) begin
        bp_mem[gi] <= '0;
        lp_mem[gi] <= '0;
      end else if (state_q == S_LP && chan_q == CH_W'(gi)) begin
        bp_mem[gi] <= bpn_q;
        lp_mem[gi] <= lpn_s;
      end
    end
  end

endmodule

// File: tb/tb_svf_multi_voice.sv
// Directed bench for svf_multi_voice: vector table plus hand-written corner sequences.
// Built with NUM_CH=3 so channel 3 is a representable out-of-range index.
module tb_svf_multi_voice;

  localparam int NUM_CH = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_chan;
  logic [7:0]  in_data;
  logic [10:0] in_alpha1;
  logic [1:0]  in_alpha2;
  logic [1:0]  in_mode;
  logic        clr_valid;
  logic [1:0]  clr_chan;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_chan;
  logic [7:0]  out_data;

  int tests = 0;
  int fails = 0;

  svf_multi_voice #(.NUM_CH(NUM_CH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_chan(in_chan), .in_data(in_data),
    .in_alpha1(in_alpha1), .in_alpha2(in_alpha2), .in_mode(in_mode),
    .clr_valid(clr_valid), .clr_chan(clr_chan),
    .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan), .out_data(out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       clr;
    logic [1:0] ch;
    int         d;
    int         a1;
    int         a2;
    int         md;
    int         exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic drive_req(input logic [1:0] ch, input int d, input int a1,
                           input int a2, input int md);
    in_chan   = ch;
    in_data   = 8'(d);
    in_alpha1 = 11'(a1);
    in_alpha2 = 2'(a2);
    in_mode   = 2'(md);
    in_valid  = 1'b1;
  endtask

  task automatic do_clear(input logic [1:0] ch);
    @(negedge clk);
    clr_valid = 1'b1;
    clr_chan  = ch;
    @(posedge clk);
    #1 clr_valid = 1'b0;
  endtask

  // Waits (bounded) for out_valid after an accept; lat = -1 on timeout.
  task automatic wait_out(output int lat, output int od, output int oc);
    int k;
    lat = -1;
    k   = 0;
    while (lat < 0 && k < 20) begin
      k++;
      @(posedge clk);
      #1;
      if (out_valid) lat = k;
    end
    od = int'($signed(out_data));
    oc = int'(out_chan);
  endtask

  task automatic run_txn(input logic [1:0] ch, input int d, input int a1, input int a2,
                         input int md, output int od, output int oc, output int lat);
    @(negedge clk);
    drive_req(ch, d, a1, a2, md);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_out(lat, od, oc);
    if (lat > 0) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int od, oc, lat, errs, nv;
    logic [7:0] hd;
    logic [1:0] hc;

    //          name          clr   ch    d    a1    a2 md exp
    vecs[0] = '{"t1_lp",      1'b1, 2'd0, 64,  1024, 2, 0, 16};
    vecs[1] = '{"t1_bp",      1'b1, 2'd0, 64,  1024, 2, 1, 32};
    vecs[2] = '{"t1_hp",      1'b1, 2'd0, 64,  1024, 2, 2, 64};
    vecs[3] = '{"t1_notch",   1'b1, 2'd0, 64,  1024, 2, 3, 80};
    vecs[4] = '{"t2_ch1_lp",  1'b0, 2'd1, 64,  1024, 2, 0, 16};
    vecs[5] = '{"t2_ch0_rep", 1'b0, 2'd0, 64,  1024, 2, 0, 40};
    vecs[6] = '{"t3_sat_1",   1'b0, 2'd2, 127, 2047, 0, 0, 126};
    vecs[7] = '{"t3_sat_2",   1'b0, 2'd2, 127, 2047, 0, 0, 127};

    rst = 1'b1; in_valid = 1'b0; in_chan = '0; in_data = '0; in_alpha1 = '0;
    in_alpha2 = '0; in_mode = '0; clr_valid = 1'b0; clr_chan = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_chan", int'(out_chan), 0);
    rst = 1'b0;
    #1 check("rst_in_ready", int'(in_ready), 1);

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].clr) do_clear(vecs[i].ch);
      run_txn(vecs[i].ch, vecs[i].d, vecs[i].a1, vecs[i].a2, vecs[i].md, od, oc, lat);
      check({vecs[i].name, "_data"}, od, vecs[i].exp);
      check({vecs[i].name, "_lat"}, lat, 3);
      check({vecs[i].name, "_chan"}, oc, int'(vecs[i].ch));
    end

    // Backpressure on ch1 (state bp=64 lp=32 -> LP 40).
    out_ready = 1'b0;
    @(negedge clk);
    drive_req(2'd1, 64, 1024, 2, 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_out(lat, od, oc);
    check("t4_data", od, 40);
    hd = out_data;
    hc = out_chan;
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (!out_valid || out_data != hd || out_chan != hc || in_ready) errs++;
    end
    check("t4_hold_errors", errs, 0);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t4_valid_drop", int'(out_valid), 0);
    check("t4_in_ready", int'(in_ready), 1);

    // Clear collides with a request: clear wins, request taken next cycle.
    @(negedge clk);
    clr_valid = 1'b1;
    clr_chan  = 2'd0;
    drive_req(2'd0, 64, 1024, 2, 0);
    #1 check("t5_in_ready_clr", int'(in_ready), 0);
    @(posedge clk);
    #1 clr_valid = 1'b0;
    #1 check("t5_in_ready_after", int'(in_ready), 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_out(lat, od, oc);
    check("t5_cleared_lp", od, 16);
    check("t5_lat", lat, 3);
    @(posedge clk);
    #1;

    // Reset in the BP state aborts with no writeback (ch0 would give 40 otherwise).
    @(negedge clk);
    drive_req(2'd0, 64, 1024, 2, 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check("t6_rst_valid", int'(out_valid), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    nv = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 if (out_valid) nv++;
    end
    check("t6_no_output", nv, 0);
    run_txn(2'd0, 64, 1024, 2, 0, od, oc, lat);
    check("t6_after_rst_lp", od, 16);

    // Out-of-range channel: accepted, straight back to IDLE, no output.
    @(negedge clk);
    drive_req(2'(NUM_CH), 64, 1024, 2, 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("t6_bad_in_ready", int'(in_ready), 1);
    nv = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 if (out_valid) nv++;
    end
    check("t6_bad_no_output", nv, 0);
    run_txn(2'd0, 64, 1024, 2, 0, od, oc, lat);
    check("t6_ch0_unchanged", od, 40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
